// File: rtl/bin_para_bcd_pkg.sv
// ---------------------------------------------------------------------------
// bin_para_bcd_pkg
// Shared definitions for the binary-to-BCD converter that drives the
// five-digit seven-segment display.
//   LIMITE / NBITS : default conversion range and shift-iteration count
//   BLANK / ERRO   : digit codes the display decoder renders as "blank" and
//                    as the error glyph
//   state_t        : converter FSM states
//   ajusta_digito  : the double-dabble "add 3 when >= 5" digit correction
// ---------------------------------------------------------------------------
package bin_para_bcd_pkg;

  // Largest value that fits in five decimal digits.
  localparam int unsigned LIMITE = 32'd99999;

  // Bits needed to represent LIMITE (2^17 = 131072 > 99999).
  localparam int unsigned NBITS = 32'd17;

  // Width of the BCD accumulator: five 4-bit digits.
  localparam int unsigned ACC_W = 32'd20;

  // Digit codes shared with the display decoder.
  localparam logic [3:0] BLANK = 4'd15;
  localparam logic [3:0] ERRO  = 4'd14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // A BCD digit that is 5 or more would become >= 10 after the next left
  // shift, so it is pre-corrected by +3 to carry into the next digit.
  function automatic logic [3:0] ajusta_digito(input logic [3:0] dig);
    logic [3:0] res;
    if (dig >= 4'd5) begin
      res = dig + 4'd3;
    end else begin
      res = dig;
    end
    return res;
  endfunction

endpackage

// File: rtl/bin_para_bcd_ajuste.sv
// ---------------------------------------------------------------------------
// bcd_ajuste
// Combinational correction of one BCD digit before a double-dabble shift.
//   dig_i : current accumulator digit
//   dig_o : dig_i + 3 when dig_i >= 5, otherwise dig_i unchanged
// ---------------------------------------------------------------------------
module bcd_ajuste
  import bin_para_bcd_pkg::*;
(
  input  logic [3:0] dig_i,
  output logic [3:0] dig_o
);

  // Digit correction ahead of the shift.
  always_comb begin
    dig_o = ajusta_digito(dig_i);
  end

endmodule

// File: rtl/bin_para_bcd.sv
// ---------------------------------------------------------------------------
// bin_para_bcd
// Sequential (shift-and-add-3) binary-to-BCD converter for the five-digit
// display. A request on start is taken only while idle; the value is then
// shifted NBITS times through a 20-bit BCD accumulator and the five digits
// are published together with a one-cycle done pulse. Values above LIMITE
// skip the conversion and publish the error glyph on every digit.
//
// Ports
//   clk      : single clock, rising edge
//   rst      : synchronous, active-high reset
//   start    : conversion request, sampled only in IDLE
//   valor    : 32-bit unsigned value to convert
//   busy     : high while the converter is not IDLE
//   done     : one-cycle pulse, digits/overflow just updated
//   overflow : last accepted valor exceeded LIMITE
//   d1..d5   : registered digits, d1 = units ... d5 = ten-thousands
// ---------------------------------------------------------------------------
module bin_para_bcd #(
  parameter int unsigned LIMITE = bin_para_bcd_pkg::LIMITE,
  parameter int unsigned NBITS  = bin_para_bcd_pkg::NBITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] valor,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [3:0]  d1,
  output logic [3:0]  d2,
  output logic [3:0]  d3,
  output logic [3:0]  d4,
  output logic [3:0]  d5
);

  import bin_para_bcd_pkg::*;

  // Counter must hold the value NBITS itself.
  localparam int CNT_W  = $clog2(NBITS + 32'd1);
  localparam int WORD_W = 20 + NBITS;

  // FSM state
  state_t state_q;
  state_t state_d;

  // Datapath registers
  logic [NBITS-1:0] sr_q;     // binary shift register
  logic [19:0]      acc_q;    // BCD accumulator, 5 digits
  logic [CNT_W-1:0] cnt_q;    // remaining shift iterations

  // Output registers
  logic        busy_q;
  logic        done_q;
  logic        ovf_q;
  logic [19:0] disp_q;        // {d5,d4,d3,d2,d1}

  // Combinational helpers
  logic              range_err_s;
  logic              last_shift_s;
  logic [19:0]       acc_adj_s;
  logic [WORD_W-1:0] word_sh_s;
  logic [19:0]       acc_sh_s;
  logic [NBITS-1:0]  sr_sh_s;

  // The range check deliberately sees all 32 bits of valor; only the low
  // NBITS bits are ever loaded into the shift path.
  assign range_err_s  = (valor > LIMITE);
  assign last_shift_s = (cnt_q == CNT_W'(1));

  // One correction cell per accumulator digit.
  for (genvar g = 0; g < 5; g++) begin : g_ajuste
    bcd_ajuste u_ajuste (
      .dig_i (acc_q[4*g +: 4]),
      .dig_o (acc_adj_s[4*g +: 4])
    );
  end

  // Accumulator and shift register move left as a single word.
  assign word_sh_s = {acc_adj_s, sr_q} << 1;
  assign acc_sh_s  = word_sh_s[WORD_W-1:NBITS];
  assign sr_sh_s   = word_sh_s[NBITS-1:0];

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (range_err_s) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (last_shift_s) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Conversion datapath and display registers. The digits and overflow are
  // written only on the edge that enters DONE, so the display never shows
  // partial accumulator contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q   <= '0;
      acc_q  <= 20'd0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      disp_q <= {5{BLANK}};
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !range_err_s) begin
            sr_q  <= valor[NBITS-1:0];
            acc_q <= 20'd0;
            cnt_q <= CNT_W'(NBITS);
          end else if (start) begin
            disp_q <= {5{ERRO}};
            ovf_q  <= 1'b1;
          end
        end
        SHIFT: begin
          acc_q <= acc_sh_s;
          sr_q  <= sr_sh_s;
          cnt_q <= cnt_q - CNT_W'(1);
          if (last_shift_s) begin
            disp_q <= acc_sh_s;
            ovf_q  <= 1'b0;
          end
        end
        DONE: begin
          cnt_q <= '0;
        end
        default: begin
          cnt_q <= '0;
        end
      endcase
      // Status flags follow the state being entered so they stay registered.
      busy_q <= (state_d != IDLE);
      done_q <= (state_d == DONE);
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = ovf_q;
  assign d1       = disp_q[3:0];
  assign d2       = disp_q[7:4];
  assign d3       = disp_q[11:8];
  assign d4       = disp_q[15:12];
  assign d5       = disp_q[19:16];

endmodule

// File: tb/tb_bin_para_bcd.sv
// ---------------------------------------------------------------------------
// tb_bin_para_bcd
// Self-checking bench for bin_para_bcd: directed cases plus 1000 random
// conversions compared against a decimal reference model (div/mod by 10).
// ---------------------------------------------------------------------------
module tb_bin_para_bcd;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] valor;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [3:0]  d1, d2, d3, d4, d5;
  logic [19:0] disp;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  bin_para_bcd dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .valor    (valor),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .d1       (d1),
    .d2       (d2),
    .d3       (d3),
    .d4       (d4),
    .d5       (d5)
  );

  always #5 clk = ~clk;

  assign disp = {d5, d4, d3, d2, d1};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: five decimal digits of v packed as {d5..d1}, or error glyph.
  function automatic logic [19:0] ref_digits(input logic [31:0] v);
    logic [19:0] r;
    logic [31:0] x;
    r = 20'd0;
    x = v;
    if (v > 32'd99999) begin
      r = 20'hEEEEE;
    end else begin
      for (int i = 0; i < 5; i++) begin
        r[4*i +: 4] = 4'(x % 32'd10);
        x = x / 32'd10;
      end
    end
    return r;
  endfunction

  // One complete conversion; entered and left at a falling edge.
  task automatic run_conv(input logic [31:0] v, input string tag);
    logic [19:0] exp_d;
    logic [19:0] prev_d;
    logic        exp_o;
    int          lat;
    int          done_cyc;
    int          done_cnt;
    int          bad;
    exp_d    = ref_digits(v);
    exp_o    = (v > 32'd99999);
    lat      = exp_o ? 1 : 18;
    prev_d   = disp;
    done_cyc = 0;
    done_cnt = 0;
    bad      = 0;
    start    = 1'b1;
    valor    = v;
    @(posedge clk);
    #1;
    start = 1'b0;
    valor = $urandom();   // must not disturb the conversion in flight
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = k;
      end
      if (busy !== (k <= lat)) bad++;
      if ((k < lat) && (disp !== prev_d)) bad++;
    end
    check_val({tag, " done_cycle"}, 32'(done_cyc), 32'(lat));
    check_val({tag, " done_pulses"}, 32'(done_cnt), 32'd1);
    check_val({tag, " busy_hold"}, 32'(bad), 32'd0);
    check_val({tag, " digits"}, {12'd0, disp}, {12'd0, exp_d});
    check_val({tag, " overflow"}, {31'd0, overflow}, {31'd0, exp_o});
  endtask

  initial begin : main
    int          dq_cyc[$];
    logic [19:0] dq_dig[$];
    int          bad;
    logic [31:0] v;

    rst   = 1'b1;
    start = 1'b0;
    valor = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("reset digits", {12'd0, disp}, 32'h000FFFFF);
    check_val("reset busy", {31'd0, busy}, 32'd0);
    check_val("reset done", {31'd0, done}, 32'd0);
    check_val("reset overflow", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed values, including both range boundaries.
    run_conv(32'd12345, "v12345");
    check_val("v12345 literal", {12'd0, disp}, 32'h00012345);
    run_conv(32'd99999, "v99999");
    run_conv(32'd100000, "v100000");
    check_val("v100000 literal", {12'd0, disp}, 32'h000EEEEE);
    run_conv(32'd0, "v0");
    run_conv(32'd131071, "v131071");
    run_conv(32'hFFFF_FFFF, "vmax");
    run_conv(32'h0002_0005, "v2_0005");
    run_conv(32'd65536, "v65536");

    // start held high through SHIFT and DONE: ignored, then re-accepted
    // in the first idle cycle.
    start = 1'b1;
    valor = 32'd42;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dq_cyc.push_back(k);
        dq_dig.push_back(disp);
      end
      if (k == 1) valor = 32'd7;
      if (k == 20) start = 1'b0;
    end
    check_val("hold pulses", 32'(dq_cyc.size()), 32'd2);
    if (dq_cyc.size() == 2) begin
      check_val("hold first cycle", 32'(dq_cyc[0]), 32'd18);
      check_val("hold first digits", {12'd0, dq_dig[0]}, 32'h00000042);
      check_val("hold second cycle", 32'(dq_cyc[1]), 32'd37);
      check_val("hold second digits", {12'd0, dq_dig[1]}, 32'h00000007);
    end else begin
      check_val("hold queue size", 32'(dq_cyc.size()), 32'd2);
    end

    // Reset in the middle of a conversion aborts it.
    run_conv(32'd500, "v500");
    start = 1'b1;
    valor = 32'd321;
    @(posedge clk);
    #1;
    start = 1'b0;
    bad = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done === 1'b1) bad++;
      if (k == 10) rst = 1'b1;
    end
    @(negedge clk);
    check_val("abort no done", 32'(bad), 32'd0);
    check_val("abort done", {31'd0, done}, 32'd0);
    check_val("abort busy", {31'd0, busy}, 32'd0);
    check_val("abort digits", {12'd0, disp}, 32'h000FFFFF);
    check_val("abort overflow", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run_conv(32'd321, "after_abort");

    // Random conversions, half drawn near the valid range.
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        v = $urandom();
      end else begin
        v = 32'($urandom_range(0, 120000));
      end
      run_conv(v, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/bin_para_bcd.md
BIN_PARA_BCD -- requirements
Module: bin_para_bcd

Interface
REQ-001 Parameter LIMITE, default 99999: largest value converted; anything above is an error.
REQ-002 Parameter NBITS, default 17: shift iterations, i.e. bits of the value converted; 2^NBITS > LIMITE.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request to convert valor; sampled only in IDLE.
REQ-006 valor  input  32  unsigned binary value from processor output register.
REQ-007 busy  output  1  high whenever state is not IDLE.
REQ-008 done  output  1  one-cycle pulse; result outputs valid and updated.
REQ-009 overflow  output  1  registered; high when last accepted valor > LIMITE.
REQ-010 d1..d5  output  4 each  registered digits to display decoders; d1 units, d5 ten-thousands.

Function
REQ-011 FSM states IDLE, SHIFT, DONE; encoding free.
REQ-012 IDLE, start=0: hold state and outputs.
REQ-013 IDLE, start=1, valor <= LIMITE: latch valor[NBITS-1:0] into shift register; clear 20-bit BCD accumulator; iteration counter = NBITS; go SHIFT.
REQ-014 IDLE, start=1, valor > LIMITE: go DONE directly; flag error internally.
REQ-015 SHIFT: per cycle, each 4-bit accumulator digit >= 5 gets +3, then accumulator:shift register shift left 1 as one word; counter decrements.
REQ-016 SHIFT: after the NBITS-th shift, go DONE.
REQ-017 On entry to DONE: d1..d5 load the accumulator digits and overflow loads 0; in the error case d1..d5 load 14 and overflow loads 1.
REQ-018 d1..d5 and overflow change only on entry to DONE (no intermediate values visible to the display).
REQ-019 DONE: done=1 for exactly that cycle; unconditionally return to IDLE.
REQ-020 Latency, start sampled high in cycle 0: normal, SHIFT in cycles 1..NBITS, done in cycle NBITS+1 (18 at default); error, done in cycle 1.
REQ-021 start while busy=1 (SHIFT or DONE): ignored, no queuing; valor changes during SHIFT do not affect the result.
REQ-022 Zero converts to digits 0,0,0,0,0, not blank.
REQ-023 Back-to-back: start high in the cycle after DONE is accepted normally.
REQ-024 Only valor bits [NBITS-1:0] feed the shift path; the range check uses all 32 bits.

Reset
REQ-025 rst=1 at a clock edge: state IDLE, busy 0, done 0, overflow 0, d1..d5 = 15 (blank), counter and accumulator cleared.
REQ-026 rst has priority over every transition; asserting it mid-SHIFT aborts the conversion with no done pulse.
REQ-027 Outputs are undefined only before the first rst edge; no reliance on initial blocks.

Structure
REQ-028 Shared package holds the digit constants BLANK=15 and ERRO=14, LIMITE, NBITS and the FSM state typedef; the existing display decoder uses the same BLANK/ERRO codes.
REQ-029 One sub-module bcd_ajuste (combinational, 4-bit in/out: +3 when >= 5) is instantiated five times; no other hierarchy.
REQ-030 Digit outputs feed the display decoders directly; no combinational path from valor to d1..d5.

Verification
REQ-031 rst held 2 cycles -> d1..d5=15, busy=0, done=0, overflow=0.
REQ-032 valor=12345, start cycle 0 -> busy cycles 1..18, done only in cycle 18, d5..d1=1,2,3,4,5, overflow=0.
REQ-033 valor=99999 -> all digits 9, done cycle 18; valor=100000 -> done cycle 1, all digits 14, overflow=1; valor=0 -> all digits 0.
REQ-034 valor=42 converted, then start held high with valor=7 during cycles 1..18 -> result 0,0,0,4,2 unchanged by 7; new start cycle 19 -> 0,0,0,0,7 at cycle 37.
REQ-035 After valor=500 completes, start valor=321, rst in cycle 10 -> no done pulse, d1..d5=15, busy=0 in the cycle after the reset edge.
REQ-036 Random valor 0..2^32-1, 1000 conversions, vs. reference model (mod/div by 10 or error) -> digits, overflow and done timing match every time.
